// File: rtl/inst_fetch_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : inst_fetch_queue_pkg
//  Purpose  : Shared types for the instruction fetch front end. Contains the
//             RV32I major opcode encoding, the queue entry record and the
//             fetch state encoding.
//  Revision : 1.0 - initial release
// ============================================================================
package inst_fetch_queue_pkg;

   // RV32I major opcodes (inst[6:0])
   typedef enum logic [6:0] {
      op_lui   = 7'b0110111,
      op_auipc = 7'b0010111,
      op_jal   = 7'b1101111,
      op_jalr  = 7'b1100111,
      op_br    = 7'b1100011,
      op_load  = 7'b0000011,
      op_store = 7'b0100011,
      op_imm   = 7'b0010011,
      op_reg   = 7'b0110011,
      op_csr   = 7'b1110011
   } rv32i_opcode;

   // One buffered instruction together with the PC it was fetched from
   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
   } inst_queue_entry_t;

   // IDLE  : no request outstanding
   // FETCH : request outstanding, its data will be kept
   // DROP  : request outstanding, its data belongs to a flushed stream
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DROP  = 2'd2
   } fetch_state_t;

endpackage : inst_fetch_queue_pkg
`default_nettype wire

// File: rtl/inst_queue_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : inst_queue_fifo
//  Purpose  : Circular buffer of fetched instructions. Head entry is presented
//             combinationally; flush clears head, tail and count and takes
//             priority over any same-cycle push or pop.
//  Ports    : clk, rst (async, active-low)
//             push/entry_in  - write entry at tail
//             pop            - retire head entry
//             flush          - discard all entries
//             entry_out      - current head entry
//             count          - occupied entries (0..DEPTH)
//             empty, full    - occupancy flags
//  Revision : 1.0 - initial release
// ============================================================================
module inst_queue_fifo
   import inst_fetch_queue_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic                         pop,
   input  logic                         flush,
   input  inst_queue_entry_t            entry_in,
   output inst_queue_entry_t            entry_out,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         empty,
   output logic                         full
);

   localparam int c_ptr_w = $clog2(DEPTH);
   localparam int c_cnt_w = $clog2(DEPTH + 1);
   localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

   inst_queue_entry_t    r_mem [DEPTH];
   logic [c_ptr_w-1:0]   r_head;
   logic [c_ptr_w-1:0]   r_tail;
   logic [c_cnt_w-1:0]   r_count;

   // Storage needs no reset: nothing is read until count says it is valid.
   always_ff @(posedge clk) begin
      if (push && !flush) begin
         r_mem[r_tail] <= entry_in;
      end
   end

   // DEPTH is a power of two, so pointers wrap naturally at their width.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (push) begin
            r_tail <= r_tail + c_ptr_w'(1);
         end
         if (pop) begin
            r_head <= r_head + c_ptr_w'(1);
         end
         case ({push, pop})
            2'b10:   r_count <= r_count + c_cnt_w'(1);
            2'b01:   r_count <= r_count - c_cnt_w'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign entry_out = r_mem[r_head];
   assign count     = r_count;
   assign empty     = (r_count == '0);
   assign full      = (r_count == c_depth);

endmodule : inst_queue_fifo
`default_nettype wire

// File: rtl/inst_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : inst_fetch_queue
//  Purpose  : Instruction fetch front end. Owns the fetch PC, issues one
//             outstanding read at a time to instruction memory, buffers the
//             returned words with their PCs and presents the head entry to
//             decode with a valid/ready handshake. A redirect flushes the
//             queue and restarts fetch; an in-flight response that predates
//             the redirect is discarded.
//  Ports    : clk, rst (async, active-low)
//             inst_mem_read/address   - request, held until inst_mem_resp
//             inst_mem_resp/rdata     - one-cycle response with data
//             redirect/redirect_pc    - flush and restart (pc[1:0] forced 0)
//             out_valid/ready         - decode handshake on head entry
//             out_inst/pc             - head entry
//             out_opcode/funct3/7     - decoded fields of out_inst
//             count                   - occupied queue entries
//  Revision : 1.0 - initial release
// ============================================================================
module inst_fetch_queue
   import inst_fetch_queue_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
   input  logic                         clk,
   input  logic                         rst,
   output logic                         inst_mem_read,
   output logic [31:0]                  inst_mem_address,
   input  logic                         inst_mem_resp,
   input  logic [31:0]                  inst_mem_rdata,
   input  logic                         redirect,
   input  logic [31:0]                  redirect_pc,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [31:0]                  out_inst,
   output logic [31:0]                  out_pc,
   output rv32i_opcode                  out_opcode,
   output logic [2:0]                   out_funct3,
   output logic [6:0]                   out_funct7,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int c_cnt_w = $clog2(DEPTH + 1);
   localparam logic [c_cnt_w-1:0] c_last_slot = c_cnt_w'(DEPTH - 1);

   fetch_state_t        r_state;
   logic                r_read;
   logic [31:0]         r_fetch_pc;
   logic [31:0]         r_req_addr;

   logic [31:0]         w_redirect_pc;
   logic [31:0]         w_next_addr;
   logic                w_push;
   logic                w_pop;
   logic                w_empty;
   logic                w_full;
   logic                w_fills_queue;
   logic                w_unused_bits;
   inst_queue_entry_t   w_push_entry;
   inst_queue_entry_t   w_head;

   assign w_redirect_pc = {redirect_pc[31:2], 2'b00};
   assign w_unused_bits = &{1'b0, redirect_pc[1:0]};
   assign w_next_addr   = r_req_addr + 32'd4;

   // A response is only kept when it belongs to the live stream.
   assign w_push       = (r_state == FETCH) && inst_mem_resp && !redirect;
   assign w_pop        = out_valid && out_ready;
   assign w_push_entry = '{inst: inst_mem_rdata, pc: r_req_addr};

   // The push being taken this cycle occupies the last free slot unless
   // decode frees one at the same time.
   assign w_fills_queue = (count == c_last_slot) && !w_pop;

   inst_queue_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (w_push),
      .pop       (w_pop),
      .flush     (redirect),
      .entry_in  (w_push_entry),
      .entry_out (w_head),
      .count     (count),
      .empty     (w_empty),
      .full      (w_full)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= IDLE;
         r_read     <= 1'b0;
         r_fetch_pc <= RESET_PC;
         r_req_addr <= RESET_PC;
      end else begin
         case (r_state)
            IDLE: begin
               if (redirect) begin
                  r_state    <= FETCH;
                  r_read     <= 1'b1;
                  r_req_addr <= w_redirect_pc;
                  r_fetch_pc <= w_redirect_pc;
               end else if (!w_full || w_pop) begin
                  // A pop from a full queue frees a slot at this edge, so
                  // issue resumes without an extra idle cycle.
                  r_state    <= FETCH;
                  r_read     <= 1'b1;
                  r_req_addr <= r_fetch_pc;
               end
            end

            FETCH: begin
               if (inst_mem_resp && !redirect) begin
                  r_fetch_pc <= w_next_addr;
                  if (w_fills_queue) begin
                     r_state <= IDLE;
                     r_read  <= 1'b0;
                  end else begin
                     r_req_addr <= w_next_addr;
                  end
               end else if (inst_mem_resp && redirect) begin
                  // Request completed this cycle, so the target can be
                  // issued immediately.
                  r_req_addr <= w_redirect_pc;
                  r_fetch_pc <= w_redirect_pc;
               end else if (redirect) begin
                  // Request is still in flight and cannot be withdrawn;
                  // remember the target and wait out the stale response.
                  r_state    <= DROP;
                  r_fetch_pc <= w_redirect_pc;
               end
            end

            DROP: begin
               if (inst_mem_resp) begin
                  r_state    <= FETCH;
                  r_req_addr <= redirect ? w_redirect_pc : r_fetch_pc;
               end
               if (redirect) begin
                  r_fetch_pc <= w_redirect_pc;
               end
            end

            default: begin
               r_state <= IDLE;
               r_read  <= 1'b0;
            end
         endcase
      end
   end

   assign inst_mem_read    = r_read;
   assign inst_mem_address = r_req_addr;

   assign out_valid  = !w_empty;
   assign out_inst   = w_head.inst;
   assign out_pc     = w_head.pc;
   assign out_opcode = rv32i_opcode'(w_head.inst[6:0]);
   assign out_funct3 = w_head.inst[14:12];
   assign out_funct7 = w_head.inst[31:25];

endmodule : inst_fetch_queue
`default_nettype wire

// File: tb/tb_inst_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_inst_fetch_queue
//  Purpose  : Self-checking bench for inst_fetch_queue. A small memory model
//             answers requests after a programmable latency; directed table
//             and hand-written sequences cover fill, full, redirect and reset
//             corners; a random phase compares the presented stream against
//             a program-order PC model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_queue;
   import inst_fetch_queue_pkg::*;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0060;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        inst_mem_read;
   logic [31:0] inst_mem_address;
   logic        inst_mem_resp = 1'b0;
   logic [31:0] inst_mem_rdata = '0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_inst;
   logic [31:0] out_pc;
   rv32i_opcode out_opcode;
   logic [2:0]  out_funct3;
   logic [6:0]  out_funct7;
   logic [2:0]  count;

   int n_cmp = 0;
   int n_bad = 0;
   int mem_lat = 1;
   logic beef_watch = 1'b0;
   logic seen_beef = 1'b0;

   inst_fetch_queue #(
      .DEPTH    (DEPTH),
      .RESET_PC (RESET_PC)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .inst_mem_read    (inst_mem_read),
      .inst_mem_address (inst_mem_address),
      .inst_mem_resp    (inst_mem_resp),
      .inst_mem_rdata   (inst_mem_rdata),
      .redirect         (redirect),
      .redirect_pc      (redirect_pc),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .out_inst         (out_inst),
      .out_pc           (out_pc),
      .out_opcode       (out_opcode),
      .out_funct3       (out_funct3),
      .out_funct7       (out_funct7),
      .count            (count)
   );

   always #5 clk = ~clk;

   // Instruction memory contents as a pure function of address.
   function automatic logic [31:0] memword(input logic [31:0] a);
      if (a == 32'h0000_0060) return 32'h00A0_0093;
      if (a == 32'h0000_0080) return 32'hDEAD_BEEF;
      return {~a[15:0], a[15:0]};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Advance one cycle; sample point is 2 time units after the rising edge,
   // after the memory model has settled its response for the cycle.
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset(input logic rdy);
      rst       = 1'b0;
      redirect  = 1'b0;
      out_ready = rdy;
      repeat (3) step();
      check("rst_read",  32'(inst_mem_read), 32'd0);
      check("rst_addr",  inst_mem_address, RESET_PC);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_count", 32'(count), 32'd0);
      rst = 1'b1;
   endtask

   // Memory model: answers each request after mem_lat cycles of read high.
   initial begin
      int cnt;
      cnt = 0;
      forever begin
         @(posedge clk);
         #1;
         inst_mem_resp = 1'b0;
         if (!rst || !inst_mem_read) begin
            cnt = 0;
         end else if (cnt >= mem_lat) begin
            inst_mem_resp  = 1'b1;
            inst_mem_rdata = memword(inst_mem_address);
            cnt = 0;
         end else begin
            cnt++;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (beef_watch && out_valid && out_inst == 32'hDEAD_BEEF) seen_beef = 1'b1;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   typedef struct {
      logic        rdy;
      logic        read;
      logic [31:0] addr;
      logic        valid;
      logic [31:0] pc;
      logic [2:0]  cnt;
   } vec_t;

   vec_t tbl [7];

   initial begin
      int          n;
      logic [31:0] exp_pc;
      logic [31:0] w;
      logic        prev_read;
      logic        prev_resp;
      logic [31:0] prev_addr;
      int          pops;

      // ---------------- 1: fill stream, latency 1, decode always ready
      tbl[0] = '{1'b1, 1'b1, 32'h60, 1'b0, 32'h00, 3'd0};
      tbl[1] = '{1'b1, 1'b1, 32'h60, 1'b0, 32'h00, 3'd0};
      tbl[2] = '{1'b1, 1'b1, 32'h64, 1'b1, 32'h60, 3'd1};
      tbl[3] = '{1'b1, 1'b1, 32'h64, 1'b0, 32'h00, 3'd0};
      tbl[4] = '{1'b1, 1'b1, 32'h68, 1'b1, 32'h64, 3'd1};
      tbl[5] = '{1'b1, 1'b1, 32'h68, 1'b0, 32'h00, 3'd0};
      tbl[6] = '{1'b1, 1'b1, 32'h6C, 1'b1, 32'h68, 3'd1};
      mem_lat = 1;
      do_reset(1'b1);
      for (int i = 0; i < 7; i++) begin
         step();
         check($sformatf("t1_read[%0d]", i),  32'(inst_mem_read), 32'(tbl[i].read));
         check($sformatf("t1_addr[%0d]", i),  inst_mem_address, tbl[i].addr);
         check($sformatf("t1_valid[%0d]", i), 32'(out_valid), 32'(tbl[i].valid));
         check($sformatf("t1_count[%0d]", i), 32'(count), 32'(tbl[i].cnt));
         if (tbl[i].valid) check($sformatf("t1_pc[%0d]", i), out_pc, tbl[i].pc);
         if (i == 2) begin
            check("t1_inst",   out_inst, 32'h00A0_0093);
            check("t1_opcode", 32'(out_opcode), 32'(op_imm));
            check("t1_funct3", 32'(out_funct3), 32'd0);
            check("t1_funct7", 32'(out_funct7), 32'd0);
         end
         out_ready = tbl[i].rdy;
      end

      // ---------------- 2: full queue stalls issue; one pop re-enables it
      do_reset(1'b0);
      n = 0;
      while (count != 3'd4 && n < 40) begin step(); n++; end
      check("t2_full_count", 32'(count), 32'd4);
      repeat (2) begin
         step();
         check("t2_full_noread", 32'(inst_mem_read), 32'd0);
         check("t2_full_hold",   32'(count), 32'd4);
      end
      check("t2_head_pc", out_pc, 32'h60);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("t2_reissue_read", 32'(inst_mem_read), 32'd1);
      check("t2_reissue_addr", inst_mem_address, 32'h70);
      check("t2_after_pop_count", 32'(count), 32'd3);
      check("t2_after_pop_pc", out_pc, 32'h64);

      // ---------------- 3: redirect with queued entries, nothing in flight
      n = 0;
      while (!(count == 3'd4 && !inst_mem_read) && n < 20) begin step(); n++; end
      check("t3_wait_idle", 32'(n < 20), 32'd1);
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0203;
      out_ready   = 1'b1;
      step();
      redirect = 1'b0;
      check("t3_count", 32'(count), 32'd0);
      check("t3_valid", 32'(out_valid), 32'd0);
      check("t3_read",  32'(inst_mem_read), 32'd1);
      check("t3_addr",  inst_mem_address, 32'h200);
      n = 0;
      while (!out_valid && n < 20) begin step(); n++; end
      check("t3_pc",   out_pc, 32'h200);
      check("t3_inst", out_inst, memword(32'h200));

      // ---------------- 4: redirect while a slow request is in flight
      mem_lat = 5;
      do_reset(1'b1);
      step();
      redirect    = 1'b1;
      redirect_pc = 32'h80;
      step();
      redirect = 1'b0;
      n = 0;
      while (!(inst_mem_read && inst_mem_address == 32'h80 && !inst_mem_resp) && n < 30) begin
         step(); n++;
      end
      check("t4_req80", inst_mem_address, 32'h80);
      step();
      beef_watch  = 1'b1;
      redirect    = 1'b1;
      redirect_pc = 32'h300;
      step();
      redirect = 1'b0;
      n = 0;
      while (!inst_mem_resp && n < 20) begin
         check("t4_hold_read", 32'(inst_mem_read), 32'd1);
         check("t4_hold_addr", inst_mem_address, 32'h80);
         step(); n++;
      end
      check("t4_resp_addr", inst_mem_address, 32'h80);
      step();
      check("t4_next_read",  32'(inst_mem_read), 32'd1);
      check("t4_next_addr",  inst_mem_address, 32'h300);
      check("t4_next_valid", 32'(out_valid), 32'd0);
      n = 0;
      while (!out_valid && n < 30) begin step(); n++; end
      check("t4_pc",   out_pc, 32'h300);
      check("t4_inst", out_inst, memword(32'h300));
      beef_watch = 1'b0;
      check("t4_beef_never_presented", 32'(seen_beef), 32'd0);

      // ---------------- 5: redirect coincident with response and pop
      mem_lat = 1;
      do_reset(1'b0);
      n = 0;
      while (!(inst_mem_resp && inst_mem_address == 32'h64) && n < 20) begin step(); n++; end
      check("t5_pre_count", 32'(count), 32'd1);
      out_ready   = 1'b1;
      redirect    = 1'b1;
      redirect_pc = 32'h400;
      step();
      redirect  = 1'b0;
      out_ready = 1'b0;
      check("t5_count", 32'(count), 32'd0);
      check("t5_valid", 32'(out_valid), 32'd0);
      check("t5_read",  32'(inst_mem_read), 32'd1);
      check("t5_addr",  inst_mem_address, 32'h400);
      n = 0;
      while (!out_valid && n < 20) begin step(); n++; end
      check("t5_pc", out_pc, 32'h400);

      // ---------------- 6: asynchronous reset mid-request
      do_reset(1'b0);
      n = 0;
      while (!(count == 3'd2 && inst_mem_read && !inst_mem_resp) && n < 20) begin step(); n++; end
      check("t6_pre_count", 32'(count), 32'd2);
      rst = 1'b0;
      #1;
      check("t6_read",  32'(inst_mem_read), 32'd0);
      check("t6_addr",  inst_mem_address, RESET_PC);
      check("t6_valid", 32'(out_valid), 32'd0);
      check("t6_count", 32'(count), 32'd0);
      repeat (2) step();
      rst = 1'b1;
      step();
      check("t6_resume_read", 32'(inst_mem_read), 32'd1);
      check("t6_resume_addr", inst_mem_address, RESET_PC);

      // ---------------- 7: random traffic against a program-order model
      mem_lat = 1;
      do_reset(1'b1);
      exp_pc    = RESET_PC;
      prev_read = 1'b0;
      prev_resp = 1'b0;
      prev_addr = '0;
      pops      = 0;
      for (int c = 0; c < 3000; c++) begin
         step();
         if (prev_read && !prev_resp) begin
            check("rnd_hold_read", 32'(inst_mem_read), 32'd1);
            check("rnd_hold_addr", inst_mem_address, prev_addr);
         end
         if (out_valid) begin
            w = memword(exp_pc);
            check("rnd_pc",     out_pc, exp_pc);
            check("rnd_inst",   out_inst, w);
            check("rnd_opcode", 32'(out_opcode), 32'(w[6:0]));
            check("rnd_funct3", 32'(out_funct3), 32'(w[14:12]));
            check("rnd_funct7", 32'(out_funct7), 32'(w[31:25]));
         end
         if ($urandom_range(0, 15) == 0) mem_lat = $urandom_range(0, 3);
         out_ready = ($urandom_range(0, 3) != 0);
         redirect  = ($urandom_range(0, 24) == 0);
         case ($urandom_range(0, 2))
            0:       redirect_pc = $urandom;
            1:       redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            default: redirect_pc = 32'($urandom_range(0, 255));
         endcase
         if (redirect) begin
            exp_pc = redirect_pc & 32'hFFFF_FFFC;
         end else if (out_valid && out_ready) begin
            exp_pc = exp_pc + 32'd4;
            pops++;
         end
         prev_read = inst_mem_read;
         prev_resp = inst_mem_resp;
         prev_addr = inst_mem_address;
      end
      redirect = 1'b0;
      check("rnd_progress", 32'(pops > 200), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_inst_fetch_queue
`default_nettype wire
